// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags, with a speculative allocation head and a committed head.
// Optional consistency checking of the commit stream is enabled by defining PJ_FREELIST_CHECK_EN.
module phys_reg_free_list #(
  parameter int NUM_PHYS_REG = 128,
  parameter int NUM_ARCH_REG = 16,
  localparam int TW    = $clog2(NUM_PHYS_REG),
  localparam int DEPTH = NUM_PHYS_REG - NUM_ARCH_REG
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          alloc_req_i,
  output logic          alloc_ready_o,
  output logic [TW-1:0] alloc_reg_o,
  input  logic          rob_phys_valid_i,
  input  logic [TW-1:0] rob_phys_reg_cl_i,
  input  logic [TW-1:0] rob_phys_reg_set_i,
  input  logic          rob_phys_mispredict_i,
  output logic [TW:0]   free_count_o,
  output logic          err_o
);

  logic [DEPTH-1:0][TW-1:0] slot_q;
  logic [TW-1:0]            spec_head_q, spec_head_d;
  logic [TW-1:0]            commit_head_q, commit_head_d;
  logic [TW:0]              inflight_q, inflight_d;
  logic                     alloc_fire, commit_ok;

  function automatic logic [TW-1:0] ptr_inc(input logic [TW-1:0] p);
    return (p == TW'(DEPTH - 1)) ? '0 : p + TW'(1);
  endfunction

  assign alloc_ready_o = (inflight_q != (TW+1)'(DEPTH)) && !rob_phys_mispredict_i;
  assign alloc_reg_o   = slot_q[spec_head_q];
  assign free_count_o  = (TW+1)'(DEPTH) - inflight_q;

  assign alloc_fire = alloc_req_i && alloc_ready_o;
  // A commit with nothing in flight is a protocol violation and leaves state untouched.
  assign commit_ok  = rob_phys_valid_i && (inflight_q != '0);

  always_comb begin
    commit_head_d = commit_ok ? ptr_inc(commit_head_q) : commit_head_q;
    spec_head_d   = spec_head_q;
    inflight_d    = inflight_q + (TW+1)'(alloc_fire) - (TW+1)'(commit_ok);
    if (rob_phys_mispredict_i) begin
      // Rollback lands on the post-commit head so a same-cycle commit is kept.
      spec_head_d = commit_head_d;
      inflight_d  = '0;
    end else if (alloc_fire) begin
      spec_head_d = ptr_inc(spec_head_q);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= TW'(NUM_ARCH_REG + i);
      spec_head_q   <= '0;
      commit_head_q <= '0;
      inflight_q    <= '0;
    end else begin
      if (commit_ok) slot_q[commit_head_q] <= rob_phys_reg_cl_i;
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      inflight_q    <= inflight_d;
    end
  end

`ifdef PJ_FREELIST_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (rob_phys_valid_i &&
        ((inflight_q == '0) || (rob_phys_reg_set_i != slot_q[commit_head_q])))
      err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_set;
  assign unused_set = ^rob_phys_reg_set_i;
  assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Randomized and directed bench for phys_reg_free_list against a rotating-queue model of the free list.
module tb_phys_reg_free_list;
  localparam int TW    = 7;
  localparam int DEPTH = 112;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          alloc_req_i;
  logic          alloc_ready_o;
  logic [TW-1:0] alloc_reg_o;
  logic          rob_phys_valid_i;
  logic [TW-1:0] rob_phys_reg_cl_i;
  logic [TW-1:0] rob_phys_reg_set_i;
  logic          rob_phys_mispredict_i;
  logic [TW:0]   free_count_o;
  logic          err_o;

  phys_reg_free_list dut (
    .clk_i                 (clk),
    .reset_i               (reset_i),
    .alloc_req_i           (alloc_req_i),
    .alloc_ready_o         (alloc_ready_o),
    .alloc_reg_o           (alloc_reg_o),
    .rob_phys_valid_i      (rob_phys_valid_i),
    .rob_phys_reg_cl_i     (rob_phys_reg_cl_i),
    .rob_phys_reg_set_i    (rob_phys_reg_set_i),
    .rob_phys_mispredict_i (rob_phys_mispredict_i),
    .free_count_o          (free_count_o),
    .err_o                 (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef PJ_FREELIST_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  // Model: store[0] is the oldest uncommitted slot; the next grant is store[infl].
  int store[$];
  int infl;
  bit merr;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    store.delete();
    for (int i = 0; i < DEPTH; i++) store.push_back(16 + i);
    infl = 0;
    merr = 1'b0;
  endtask

  task automatic model_step();
    bit cok, fire;
    if (reset_i) return;
    cok  = rob_phys_valid_i && infl > 0;
    fire = alloc_req_i && infl != DEPTH && !rob_phys_mispredict_i;
    if (CHECK_EN && rob_phys_valid_i && (infl == 0 || int'(rob_phys_reg_set_i) != store[0]))
      merr = 1'b1;
    if (cok) begin
      void'(store.pop_front());
      store.push_back(int'(rob_phys_reg_cl_i));
      infl--;
    end
    if (rob_phys_mispredict_i) infl = 0;
    else if (fire) infl++;
  endtask

  always @(negedge clk) begin
    chk("ready", int'(alloc_ready_o), int'(infl != DEPTH && !rob_phys_mispredict_i));
    chk("reg",   int'(alloc_reg_o),   store[infl % DEPTH]);
    chk("free",  int'(free_count_o),  DEPTH - infl);
    chk("err",   int'(err_o),         int'(merr));
  end

  task automatic idle_inputs();
    alloc_req_i = 0; rob_phys_valid_i = 0; rob_phys_mispredict_i = 0;
    rob_phys_reg_cl_i = '0; rob_phys_reg_set_i = '0;
  endtask

  task automatic drive(input bit a, input bit v, input int cl, input int set, input bit m);
    alloc_req_i = a; rob_phys_valid_i = v; rob_phys_mispredict_i = m;
    rob_phys_reg_cl_i = TW'(cl); rob_phys_reg_set_i = TW'(set);
  endtask

  task automatic cyc(input bit a, input bit v, input int cl, input int set, input bit m);
    drive(a, v, cl, set, m);
    @(posedge clk);
    model_step();
    #1 idle_inputs();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 idle_inputs();
    reset_i = 1;
    model_reset();
    @(posedge clk);
    #1 reset_i = 0;
  endtask

  initial begin
    idle_inputs();
    reset_i = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_i = 0;

    // Reset values.
    chk("rst_ready", int'(alloc_ready_o), 1);
    chk("rst_reg",   int'(alloc_reg_o),   16);
    chk("rst_free",  int'(free_count_o),  112);
    chk("rst_err",   int'(err_o),         0);

    // Three back-to-back grants.
    for (int i = 0; i < 3; i++) begin
      chk("grant3", int'(alloc_reg_o), 16 + i);
      cyc(1, 0, 0, 0, 0);
    end
    chk("free109", int'(free_count_o), 109);

    // Fill completely, then an extra request must be ignored.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 0, 0);
    chk("full_ready", int'(alloc_ready_o), 0);
    chk("full_free",  int'(free_count_o),  0);
    cyc(1, 0, 0, 0, 0);
    chk("full_hold", int'(free_count_o), 0);
    drive(0, 1, 5, 16, 0);
    #1 chk("no_bypass", int'(alloc_ready_o), 0);
    @(posedge clk); model_step(); #1 idle_inputs();
    chk("freed_ready", int'(alloc_ready_o), 1);
    chk("freed_reg",   int'(alloc_reg_o),   5);

    // Commit then mispredict rolls back to the committed head.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 3, 16, 0);
    cyc(0, 0, 0, 0, 1);
    chk("mp_reg",  int'(alloc_reg_o),  17);
    chk("mp_free", int'(free_count_o), 112);
    cyc(1, 0, 0, 0, 0);
    chk("mp_next", int'(alloc_reg_o), 18);

    // Mispredict + allocate + commit in one cycle.
    do_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    drive(1, 1, 7, 16, 1);
    #1 chk("mpc_ready", int'(alloc_ready_o), 0);
    @(posedge clk); model_step(); #1 idle_inputs();
    chk("mpc_free", int'(free_count_o), 112);
    chk("mpc_reg",  int'(alloc_reg_o),  17);

    // Wrong set tag on commit.
    do_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 9, 40, 0);
    chk("err_set", int'(err_o), int'(CHECK_EN));
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("err_sticky", int'(err_o), int'(CHECK_EN));
    do_reset();
    chk("err_clr", int'(err_o), 0);

    // Randomized traffic with an asynchronous reset in the middle.
    for (int n = 0; n < 3000; n++) begin
      bit a, v, m;
      int cl, set;
      if (n == 1500) begin
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
        @(posedge clk);
        #3 idle_inputs();
        reset_i = 1;
        model_reset();
        #1;
        chk("async_ready", int'(alloc_ready_o), 1);
        chk("async_reg",   int'(alloc_reg_o),   16);
        chk("async_free",  int'(free_count_o),  112);
        @(posedge clk);
        #1 reset_i = 0;
      end
      a   = ($urandom % 4) != 0;
      v   = (infl > 0) ? (($urandom % 3) == 0) : (($urandom % 25) == 0);
      m   = ($urandom % 60) == 0;
      cl  = int'($urandom % 128);
      set = (($urandom % 20) == 0) ? int'($urandom % 128) : store[0];
      cyc(a, v, cl, set, m);
    end

    @(negedge clk);
    #1 $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

- Manages allocation of physical register tags for the rename stage and returns freed tags at commit.
- Sits between rename, the ROB and the physical register file: it supplies the destination tag whose valid bit the register file later sets, and absorbs the ROB's per-commit clear/set/mispredict stream.
- Implemented as a circular tag store with a speculative allocation head and a committed head. Recovery from a mispredict is a single-cycle head rollback.

## Interface

Parameters:
- NUM_PHYS_REG, 128, total physical registers; tag width TW = $clog2(NUM_PHYS_REG).
- NUM_ARCH_REG, 16, architectural registers. Tags 0..NUM_ARCH_REG-1 are mapped at reset.
- DEPTH (derived), NUM_PHYS_REG-NUM_ARCH_REG, tag store entries (112 by default).

Ports:
- clk_i  in  1  clock; one clock domain.
- reset_i  in  1  asynchronous, active-high reset.
- alloc_req_i  in  1  rename requests one destination tag this cycle.
- alloc_ready_o  out  1  a free tag is available and the request may fire.
- alloc_reg_o  out  TW  tag granted when alloc_req_i && alloc_ready_o.
- rob_phys_valid_i  in  1  the ROB commits one instruction that wrote a register.
- rob_phys_reg_cl_i  in  TW  the previous mapping being freed.
- rob_phys_reg_set_i  in  TW  the tag becoming architectural; consumed only by the check logic.
- rob_phys_mispredict_i  in  1  flush; discard all uncommitted allocations.
- free_count_o  out  TW+1  number of tags allocatable from the speculative view.
- err_o  out  1  sticky consistency error; see Configuration.

## Operation

State:
- slot[0..DEPTH-1], each TW bits.
- spec_head, commit_head: pointers, mod DEPTH.
- inflight: count of allocations not yet committed, 0..DEPTH.
- err.

Reset (asynchronous):
- slot[i]=NUM_ARCH_REG+i.
- spec_head=commit_head=0, inflight=0, err=0.
- Outputs at reset: alloc_ready_o=1, alloc_reg_o=16, free_count_o=112, err_o=0.

Combinational outputs:
- alloc_ready_o = (inflight != DEPTH) && !rob_phys_mispredict_i.
- alloc_reg_o = slot[spec_head].
- free_count_o = DEPTH - inflight.

Allocate (alloc_req_i && alloc_ready_o):
- spec_head <= spec_head+1, wrapping DEPTH-1 -> 0.
- inflight +1.

Commit (rob_phys_valid_i):
- slot[commit_head] <= rob_phys_reg_cl_i.
- commit_head +1 with wrap.
- inflight -1.
- Commits must be in allocation order, so the slot being overwritten always holds the tag just made architectural.

Mispredict (rob_phys_mispredict_i):
- spec_head <= commit_head next-state value (includes a same-cycle commit).
- inflight <= 0.

Simultaneous events:
- Allocate + commit: both apply; inflight is unchanged.
- Mispredict + allocate: the allocate is suppressed because alloc_ready_o=0.
- Mispredict + commit: the commit is applied first, then the rollback.
- Commit with inflight=0: a protocol violation. State is unchanged except that err is set when the check is enabled.
- Freed tag while full: no same-cycle bypass. alloc_ready_o rises the cycle after the commit.

## Timing

- Allocation has zero-cycle grant: the tag is valid in the same cycle as the request. Pointer updates land at the next posedge.
- A freed tag becomes allocatable at the earliest DEPTH-inflight allocations later; it is never re-granted in the cycle it is freed.
- A mispredict takes effect at the next posedge. The following cycle, alloc_reg_o = slot[commit_head] and free_count_o = DEPTH.
- Reset asserted mid-operation returns all state to reset values immediately, without waiting for a clock.

## Configuration

- PJ_FREELIST_CHECK_EN defined: on each commit, err is set if inflight==0 or rob_phys_reg_set_i != slot[commit_head]. err is sticky until reset; err_o=err.
- Undefined: the check logic is absent and err_o is tied to 0.

## Test plan

- Reset, no stimulus -> alloc_ready_o=1, alloc_reg_o=16, free_count_o=112, err_o=0.
- alloc_req_i held for 3 cycles -> grants 16, 17, 18; free_count_o=109.
- 112 allocations -> alloc_ready_o=0, free_count_o=0, and further requests are ignored.
  - Then commit set=16, cl=5 -> next cycle alloc_ready_o=1, alloc_reg_o=5 (wrapped slot 0).
- Allocate 16..19; commit set=16, cl=3; then mispredict -> next cycle alloc_reg_o=17, free_count_o=112.
  - Following commit-order allocations yield 17, 18, ...
- Mispredict in the same cycle as alloc_req_i and a commit (set=16, cl=7) after 2 allocations -> no grant, spec_head=commit_head=1, free_count_o=112.
- With PJ_FREELIST_CHECK_EN: after one allocation (16), commit set=40 -> err_o=1 next cycle and it stays 1 until reset_i.
  - Without the macro -> err_o remains 0.
